// File: rtl/des_round_sequencer_pkg.sv
// Shared types, widths and the DES key-rotation schedule for the round sequencer.
// The optional decrypt path is selected with the DES_DECRYPT_EN macro in the design files.
package des_round_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BLK_W   = 64;
  localparam int HALF_W  = 32;
  localparam int KEY_W   = 56;
  localparam int KHALF_W = 28;

  // Left-shift amount applied before round r (1-based). Indices outside 1..16 return 1.
  function automatic logic [1:0] shift_amt(input int r);
    case (r)
      3, 4, 5, 6, 7, 8, 10, 11, 12, 13, 14, 15: return 2'd2;
      default:                                 return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/des_round_sequencer_if.sv
// Block-in / result-out handshake bundle for the DES round sequencer.
// The master drives blocks in and takes results; the slave is the sequencer.
interface des_round_sequencer_if;
  import des_round_sequencer_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BLK_W-1:0]   in_block;
  logic [KEY_W-1:0]   in_key;
  logic               in_decrypt;
  logic               out_valid;
  logic               out_ready;
  logic [BLK_W-1:0]   out_block;

  modport master (
    output in_valid, in_block, in_key, in_decrypt, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, in_key, in_decrypt, out_ready,
    output in_ready, out_valid, out_block
  );

endinterface

// File: rtl/des_round_sequencer_key_rotator.sv
// des_key_rotator: combinational rotate of {C,D} by 1 or 2 bits, each 28-bit half
// independently. The right-rotate path exists only when DES_DECRYPT_EN is defined.
module des_key_rotator
  import des_round_sequencer_pkg::*;
(
  input  logic [KEY_W-1:0] cd_in,
  input  logic             two,
  input  logic             right,
  output logic [KEY_W-1:0] cd_out
);

  function automatic logic [KHALF_W-1:0] rotl(input logic [KHALF_W-1:0] x, input logic by2);
    return by2 ? {x[KHALF_W-3:0], x[KHALF_W-1:KHALF_W-2]} : {x[KHALF_W-2:0], x[KHALF_W-1]};
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [KHALF_W-1:0] rotr(input logic [KHALF_W-1:0] x, input logic by2);
    return by2 ? {x[1:0], x[KHALF_W-1:2]} : {x[0], x[KHALF_W-1:1]};
  endfunction

  // Rotate both halves in the requested direction
  always_comb begin
    cd_out = {rotl(cd_in[KEY_W-1:KHALF_W], two), rotl(cd_in[KHALF_W-1:0], two)};
    if (right) begin
      cd_out = {rotr(cd_in[KEY_W-1:KHALF_W], two), rotr(cd_in[KHALF_W-1:0], two)};
    end
  end
`else
  logic unused_right;
  assign unused_right = right;

  // Left rotate only; no decrypt direction is built
  always_comb begin
    cd_out = {rotl(cd_in[KEY_W-1:KHALF_W], two), rotl(cd_in[KHALF_W-1:0], two)};
  end
`endif

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: owns L/R, C/D and the round counter, and drives one
// shared external round datapath (f_r/f_cd out, f_result back) for ROUNDS cycles.
// Define DES_DECRYPT_EN to honour in_decrypt and build the right-rotate key path.
module des_round_sequencer
  import des_round_sequencer_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  des_round_sequencer_if.slave bus,
  output logic [HALF_W-1:0]   f_r,
  output logic [KEY_W-1:0]    f_cd,
  input  logic [HALF_W-1:0]   f_result,
  output logic                busy,
  output logic [3:0]          round_idx
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   l_q, r_q;
  logic [KEY_W-1:0]    cd_q;
  logic                mode_q;
  logic [3:0]          round_q;
  logic [BLK_W-1:0]    out_q;

  logic                mode_in;
  logic                last_rnd;
  logic [KEY_W-1:0]    rot_in, rot_out;
  logic                rot_two, rot_right;

`ifdef DES_DECRYPT_EN
  assign mode_in = bus.in_decrypt;
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.in_decrypt;
  assign mode_in = 1'b0;
`endif

  assign last_rnd = (round_q == LAST_RND);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, run ROUNDS rounds, hold result until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = ROUND;
      ROUND:   if (last_rnd)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready = 1'b1;
      ROUND:   busy = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  // Rotator operand select: first encrypt shift at accept, then the per-round shift.
  // Decrypt walks the schedule backwards with right rotations starting from K16.
  always_comb begin
    rot_in    = cd_q;
    rot_two   = 1'b0;
    rot_right = 1'b0;
    if (state_q == IDLE) begin
      rot_in  = bus.in_key;
      rot_two = (shift_amt(1) == 2'd2);
    end else if (mode_q) begin
      rot_right = 1'b1;
      rot_two   = (shift_amt(16 - int'(round_q)) == 2'd2);
    end else begin
      rot_two   = (shift_amt(int'(round_q) + 2) == 2'd2);
    end
  end

  des_key_rotator u_rot (
    .cd_in  (rot_in),
    .two    (rot_two),
    .right  (rot_right),
    .cd_out (rot_out)
  );

  // Block, key and round registers; the last round also captures the swapped result
  always_ff @(posedge clk) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      cd_q    <= '0;
      mode_q  <= 1'b0;
      round_q <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            l_q     <= bus.in_block[BLK_W-1:HALF_W];
            r_q     <= bus.in_block[HALF_W-1:0];
            cd_q    <= mode_in ? bus.in_key : rot_out;
            mode_q  <= mode_in;
            round_q <= '0;
          end
        end
        ROUND: begin
          l_q     <= r_q;
          r_q     <= l_q ^ f_result;
          round_q <= round_q + 4'd1;
          if (!last_rnd) cd_q  <= rot_out;
          if (last_rnd)  out_q <= {l_q ^ f_result, r_q};
        end
        default: ;
      endcase
    end
  end

  assign bus.out_block = out_q;
  assign f_r           = r_q;
  assign f_cd          = cd_q;
  assign round_idx     = round_q;

endmodule
